// File: rtl/fft_addr_gen.sv
// fft_addr_gen: butterfly top/bottom address and twiddle index generator for one FFT stage
module fft_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int TW_W   = 9
) (
    input  logic              clk,
    input  logic              i_resetn,
    input  logic [2:0]        i_point_configuration,
    input  logic              i_working,
    input  logic              i_new_stage_trigger,
    input  logic [9:0]        i_calcs_per_group,
    input  logic [9:0]        i_stride,
    input  logic [7:0]        i_stride_index_offset,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr_top,
    output logic [ADDR_W-1:0] o_addr_bot,
    output logic [TW_W-1:0]   o_tw_index,
    output logic              o_last,
    output logic              o_stage_done,
    output logic              o_busy,
    output logic              o_cfg_err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [10:0]       n_full;
    logic              legal, start, run, accept, last_beat;
    logic [9:0]        last_n, c_reg, k, n;
    logic [ADDR_W-1:0] s_reg, b;
    logic [7:0]        t_reg;
    logic [TW_W-1:0]   t;
    logic              cfg_err;
    assign n_full    = 11'd16 << i_point_configuration;
    assign legal     = i_point_configuration != 3'd7 && |i_calcs_per_group && |i_stride
                       && {1'b0, i_stride} < n_full;
    assign start     = state == IDLE && i_new_stage_trigger && i_working && legal;
    assign run       = state == RUN;
    assign accept    = run && i_ready && i_working;
    assign last_beat = n == last_n;
    always_ff @(posedge clk) begin
        if (!i_resetn) state <= IDLE;
        else           state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = !i_working ? IDLE : (i_ready && last_beat) ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            last_n  <= '0;
            c_reg   <= '0;
            s_reg   <= '0;
            t_reg   <= '0;
            b       <= '0;
            k       <= '0;
            t       <= '0;
            n       <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= state == IDLE && i_new_stage_trigger && i_working && !legal;
            if (start) begin
                last_n <= n_full[10:1] - 10'd1;
                c_reg  <= i_calcs_per_group;
                s_reg  <= ADDR_W'(i_stride);
                t_reg  <= i_stride_index_offset;
                b      <= '0;
                k      <= '0;
                t      <= '0;
                n      <= '0;
            end else if (accept) begin
                n <= n + 10'd1;
                // group wrap: restart twiddles and jump over the bottom half of this group
                if (k == c_reg - 10'd1) begin
                    k <= '0;
                    t <= '0;
                    b <= b + (s_reg << 1);
                end else begin
                    k <= k + 10'd1;
                    t <= t + TW_W'(t_reg);
                end
            end
        end
    end
    assign o_valid      = run;
    assign o_busy       = run;
    assign o_addr_top   = run ? b + ADDR_W'(k) : '0;
    assign o_addr_bot   = run ? b + ADDR_W'(k) + s_reg : '0;
    assign o_tw_index   = run ? t : '0;
    assign o_last       = run && last_beat;
    assign o_stage_done = state == DONE;
    assign o_cfg_err    = cfg_err;
endmodule
